// File: rtl/cla_pipe_addsub_if.sv
// rtl/cla_pipe_addsub_if.sv - operand/result handshake bundle for cla_pipe_addsub
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined segmented carry-lookahead adder/subtractor
// Define CLA_SAT_EN to clamp out_sum to signed max/min on overflow.
module cla_pipe_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  cla_pipe_addsub_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;

  // Each stage carries the whole operand pair forward; segments beyond k are still unsummed.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             cm;
  } stage_t;

  // Returns {carry out, carry into top bit, sum} for one segment.
  function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;
    logic [NG-1:0]  gp;
    logic [NG-1:0]  gg;
    logic [NG:0]    gc;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc[0] = cin;
    for (int j = 0; j < NG; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int i = 0; i < 3; i++) c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
    end
    c[SEG] = gc[NG];
    return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
  endfunction

  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              adv;

  assign adv          = ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];
  end

  always_comb begin
    stage_t         src;
    logic [SEG+1:0] res;
    src = '0;
    res = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src.a   = bus.in_a;
        src.b   = bus.in_b ^ {WIDTH{bus.in_sub}};
        src.sum = '0;
        src.c   = bus.in_cin;
        src.cm  = 1'b0;
      end else begin
        src = stage_q[(k == 0) ? 0 : k-1];
      end
      res                         = seg_add(src.a[k*SEG +: SEG], src.b[k*SEG +: SEG], src.c);
      stage_d[k]                  = src;
      stage_d[k].sum[k*SEG +: SEG] = res[SEG-1:0];
      stage_d[k].cm               = res[SEG];
      stage_d[k].c                = res[SEG+1];
    end
`ifdef CLA_SAT_EN
    // Operands share a sign on overflow, so operand A's MSB gives the true result's sign.
    if (stage_d[STAGES-1].c ^ stage_d[STAGES-1].cm)
      stage_d[STAGES-1].sum = stage_d[STAGES-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                           : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Stages only load on a valid beat so the outputs keep the last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_d[k]) stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_sum   = stage_q[STAGES-1].sum;
  assign bus.out_cout  = stage_q[STAGES-1].c;
  assign bus.out_ovf   = stage_q[STAGES-1].c ^ stage_q[STAGES-1].cm;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - directed-vector bench for cla_pipe_addsub (64b/4 stages and 16b/1 stage)
module tb_cla_pipe_addsub;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cla_pipe_addsub_if #(.WIDTH(64)) bus ();
  cla_pipe_addsub_if #(.WIDTH(16)) bus16 ();

  cla_pipe_addsub #(.WIDTH(64), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  cla_pipe_addsub #(.WIDTH(16), .STAGES(1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0; bus16.in_sub = 1'b0;
    bus16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_sum !== 64'h0) begin miscompares++; $display("FAIL reset out_sum: got %h want 0", bus.out_sum); end
    vectors++; if (bus.out_cout !== 1'b0) begin miscompares++; $display("FAIL reset out_cout: got %b want 0", bus.out_cout); end
    vectors++; if (bus.out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset out_ovf: got %b want 0", bus.out_ovf); end
  endtask

  task automatic test_add_sub();
    logic [63:0] ta [6];
    logic [63:0] tb [6];
    logic [63:0] ts [6];
    logic        tc [6];
    logic        tsub [6];
    logic        tco [6];
    logic        tov [6];
    int          lat;
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'h0; tc[0] = 1; tsub[0] = 0;
    ts[0] = 64'h0; tco[0] = 1; tov[0] = 0;
    ta[1] = 64'd5; tb[1] = 64'd7; tc[1] = 1; tsub[1] = 1;
    ts[1] = 64'hFFFF_FFFF_FFFF_FFFE; tco[1] = 0; tov[1] = 0;
    ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'd1; tc[2] = 0; tsub[2] = 0;
`ifdef CLA_SAT_EN
    ts[2] = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    ts[2] = 64'h8000_0000_0000_0000;
`endif
    tco[2] = 0; tov[2] = 1;
    ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'd1; tc[3] = 1; tsub[3] = 1;
`ifdef CLA_SAT_EN
    ts[3] = 64'h8000_0000_0000_0000;
`else
    ts[3] = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    tco[3] = 1; tov[3] = 1;
    ta[4] = 64'h0000_0000_FFFF_FFFF; tb[4] = 64'd1; tc[4] = 0; tsub[4] = 0;
    ts[4] = 64'h0000_0001_0000_0000; tco[4] = 0; tov[4] = 0;
    ta[5] = 64'h0123_4567_89AB_CDEF; tb[5] = 64'h0123_4567_89AB_CDEF; tc[5] = 1; tsub[5] = 1;
    ts[5] = 64'h0; tco[5] = 1; tov[5] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = ta[i]; bus.in_b = tb[i];
      bus.in_cin = tc[i]; bus.in_sub = tsub[i]; bus.out_ready = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL vec%0d in_ready: got %b want 1", i, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL vec%0d latency: got %0d want 4", i, lat); end
      vectors++; if (bus.out_sum !== ts[i]) begin miscompares++; $display("FAIL vec%0d out_sum: got %h want %h", i, bus.out_sum, ts[i]); end
      vectors++; if (bus.out_cout !== tco[i]) begin miscompares++; $display("FAIL vec%0d out_cout: got %b want %b", i, bus.out_cout, tco[i]); end
      vectors++; if (bus.out_ovf !== tov[i]) begin miscompares++; $display("FAIL vec%0d out_ovf: got %b want %b", i, bus.out_ovf, tov[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int          sent;
    int          rx;
    logic        exp_rdy;
    logic [63:0] exp_sum;
    sent = 0;
    rx = 0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (sent < 8);
      bus.in_a      = 64'(sent + 1);
      bus.in_b      = 64'(sent + 1) << 32;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      #1;
      exp_rdy = !(c == 4 || c == 5);
      vectors++; if (bus.in_ready !== exp_rdy) begin miscompares++; $display("FAIL b2b in_ready cyc%0d: got %b want %b", c, bus.in_ready, exp_rdy); end
      if (bus.out_valid && bus.out_ready) begin
        exp_sum = (64'(rx + 1) << 32) | 64'(rx + 1);
        vectors++; if (bus.out_sum !== exp_sum) begin miscompares++; $display("FAIL b2b out_sum beat%0d: got %h want %h", rx, bus.out_sum, exp_sum); end
        rx++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++; if (rx !== 8) begin miscompares++; $display("FAIL b2b beat count: got %0d want 8", rx); end
    repeat (5) @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b extra beat: out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_a = 64'd1; bus.in_b = 64'd2;
    bus.in_cin = 1'b0; bus.in_sub = 1'b0;
    @(negedge clk);
    bus.in_a = 64'd3; bus.in_b = 64'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid out_valid after rst: got %b want 0", bus.out_valid); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid ghost beat cyc%0d: out_valid %b want 0", i, bus.out_valid); end
    end
    bus.in_valid = 1'b1; bus.in_a = 64'd10; bus.in_b = 64'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rstmid latency: got %0d want 4", lat); end
    vectors++; if (bus.out_sum !== 64'd30) begin miscompares++; $display("FAIL rstmid out_sum: got %h want 1e", bus.out_sum); end
  endtask

  task automatic test_narrow();
    int lat;
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.in_a = 16'h1234; bus16.in_b = 16'h0FF0;
    bus16.in_cin = 1'b1; bus16.in_sub = 1'b0; bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 1;
    while (bus16.out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL narrow latency: got %0d want 1", lat); end
    vectors++; if (bus16.out_sum !== 16'h2225) begin miscompares++; $display("FAIL narrow out_sum: got %h want 2225", bus16.out_sum); end
    vectors++; if (bus16.out_cout !== 1'b0) begin miscompares++; $display("FAIL narrow out_cout: got %b want 0", bus16.out_cout); end
    vectors++; if (bus16.out_ovf !== 1'b0) begin miscompares++; $display("FAIL narrow out_ovf: got %b want 0", bus16.out_ovf); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
